spi_flash_slave: RTL

SPI_FLASH_SLAVE -- requirements
Module: spi_flash_slave

---
 rtl/spi_flash_slave.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_slave.sv
// SPI-mode-0 serial flash slave model: WREN/WRDI/RDSR/READ/REMS/PP/SE over a small byte array.
// Define SPI_FLASH_SLAVE_BUSY_EN for a timed one-byte-per-clk erase walk with a live busy flag.
module spi_flash_slave #(
  parameter int         MEM_AW = 8,
  parameter logic [7:0] MFR_ID = 8'hEF,
  parameter logic [7:0] DEV_ID = 8'h17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cs,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  output logic wel,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    DATA_IN  = 3'd3,
    DATA_OUT = 3'd4,
    IGNORE   = 3'd5
  } state_t;

  localparam int DEPTH = 1 << MEM_AW;
  localparam int PW    = (MEM_AW < 8) ? MEM_AW : 8;

  logic [7:0]        mem [DEPTH];
  logic [1:0]        cs_sync, sck_sync, mosi_sync;
  logic              cs_prev, sck_prev;
  logic              cs_fall, cs_rise, sck_rise, sck_fall;
  state_t            state_r, state_s;
  logic [4:0]        bit_cnt_r;
  logic [6:0]        rx_shift_r;
  logic [7:0]        rx_next;
  logic [7:0]        op_r;
  logic [MEM_AW-1:0] ptr_r, ptr_page_s;
  logic [7:0]        tx_shift_r, tx_byte_s;
  logic [2:0]        tx_cnt_r;
  logic              miso_r, wel_r, erase_armed_r, wrote_r;
  logic              byte_done, erase_go_s, wr_en_s, busy_s;
  logic [7:0]        wr_data_s;

  // Two-flop synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_prev   <= cs_sync[1];
      sck_prev  <= sck_sync[1];
    end
  end

  assign cs_fall   = cs_prev & ~cs_sync[1];
  assign cs_rise   = ~cs_prev & cs_sync[1];
  assign sck_rise  = ~sck_prev & sck_sync[1];
  assign sck_fall  = sck_prev & ~sck_sync[1];
  assign rx_next   = {rx_shift_r, mosi_sync[1]};
  assign byte_done = sck_rise && (bit_cnt_r[2:0] == 3'd7);

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state decode and frame-end erase trigger
  always_comb begin
    state_s    = state_r;
    erase_go_s = 1'b0;
    if (cs_rise) begin
      state_s    = IDLE;
      erase_go_s = (state_r == IGNORE) && erase_armed_r && wel_r;
    end else begin
      case (state_r)
        IDLE: if (cs_fall) state_s = CMD; else state_s = IDLE;
        CMD: begin
          if (byte_done) begin
            if (busy_s && (rx_next != 8'h05)) begin
              state_s = IGNORE;
            end else begin
              case (rx_next)
                8'h05:                      state_s = DATA_OUT;
                8'h03, 8'h90, 8'h02, 8'h20: state_s = ADDR;
                default:                    state_s = IGNORE;
              endcase
            end
          end else begin
            state_s = CMD;
          end
        end
        ADDR: begin
          if (sck_rise && (bit_cnt_r == 5'd23)) begin
            case (op_r)
              8'h03, 8'h90: state_s = DATA_OUT;
              8'h02:        state_s = DATA_IN;
              default:      state_s = IGNORE;
            endcase
          end else begin
            state_s = ADDR;
          end
        end
        default: state_s = state_r;
      endcase
    end
  end

  // Page-wrapping increment for programming and the next outgoing byte
  always_comb begin
    ptr_page_s         = ptr_r;
    ptr_page_s[PW-1:0] = ptr_r[PW-1:0] + PW'(1);
    case (op_r)
      8'h05:   tx_byte_s = {6'b000000, wel_r, busy_s};
      8'h03:   tx_byte_s = mem[ptr_r];
      8'h90:   tx_byte_s = ptr_r[0] ? DEV_ID : MFR_ID;
      default: tx_byte_s = 8'h00;
    endcase
  end

  assign wr_en_s   = (state_r == DATA_IN) && byte_done && wel_r && !cs_rise;
  assign wr_data_s = mem[ptr_r] & rx_next;

  // Shift registers, address pointer, opcode, write-enable latch and miso
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r     <= 5'd0;
      rx_shift_r    <= 7'd0;
      op_r          <= 8'h00;
      ptr_r         <= '0;
      tx_shift_r    <= 8'h00;
      tx_cnt_r      <= 3'd0;
      miso_r        <= 1'b0;
      wel_r         <= 1'b0;
      erase_armed_r <= 1'b0;
      wrote_r       <= 1'b0;
    end else if (cs_rise) begin
      if (erase_go_s || wrote_r) wel_r <= 1'b0;
      erase_armed_r <= 1'b0;
      wrote_r       <= 1'b0;
      miso_r        <= 1'b0;
    end else if (cs_fall) begin
      bit_cnt_r     <= 5'd0;
      rx_shift_r    <= 7'd0;
      tx_cnt_r      <= 3'd0;
      erase_armed_r <= 1'b0;
      wrote_r       <= 1'b0;
      miso_r        <= 1'b0;
    end else begin
      if (sck_rise && (state_r == CMD || state_r == ADDR || state_r == DATA_IN)) begin
        rx_shift_r <= rx_next[6:0];
        bit_cnt_r  <= (state_s != state_r) ? 5'd0 : bit_cnt_r + 5'd1;
      end
      if (state_r == CMD && byte_done) begin
        op_r <= rx_next;
        if (!busy_s && rx_next == 8'h06) wel_r <= 1'b1;
        if (!busy_s && rx_next == 8'h04) wel_r <= 1'b0;
      end
      if (state_r == ADDR && sck_rise) begin
        ptr_r <= {ptr_r[MEM_AW-2:0], mosi_sync[1]};
        if (bit_cnt_r == 5'd23 && op_r == 8'h20) erase_armed_r <= 1'b1;
      end
      if (wr_en_s) begin
        ptr_r   <= ptr_page_s;
        wrote_r <= 1'b1;
      end
      // A new byte is fetched on the first falling edge of each output byte
      if (state_r != DATA_OUT) begin
        miso_r <= 1'b0;
      end else if (sck_fall) begin
        tx_cnt_r <= tx_cnt_r + 3'd1;
        if (tx_cnt_r == 3'd0) begin
          miso_r     <= tx_byte_s[7];
          tx_shift_r <= {tx_byte_s[6:0], 1'b0};
          if (op_r != 8'h05) ptr_r <= ptr_r + MEM_AW'(1);
        end else begin
          miso_r     <= tx_shift_r[7];
          tx_shift_r <= {tx_shift_r[6:0], 1'b0};
        end
      end
    end
  end

`ifdef SPI_FLASH_SLAVE_BUSY_EN
  logic              busy_r;
  logic [MEM_AW-1:0] erase_cnt_r;

  // Erase walk sequencer; reset abandons a walk in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      erase_cnt_r <= '0;
    end else if (erase_go_s) begin
      busy_r      <= 1'b1;
      erase_cnt_r <= '0;
    end else if (busy_r) begin
      erase_cnt_r <= erase_cnt_r + MEM_AW'(1);
      if (erase_cnt_r == {MEM_AW{1'b1}}) busy_r <= 1'b0;
    end else begin
      erase_cnt_r <= erase_cnt_r;
    end
  end

  assign busy_s = busy_r;

  // Array write port (not reset): erase walk or program byte
  always_ff @(posedge clk) begin
    if (busy_r)       mem[erase_cnt_r] <= 8'hFF;
    else if (wr_en_s) mem[ptr_r]       <= wr_data_s;
  end
`else
  assign busy_s = 1'b0;

  // Array write port (not reset): whole-array erase or program byte
  always_ff @(posedge clk) begin
    if (erase_go_s) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else if (wr_en_s) begin
      mem[ptr_r] <= wr_data_s;
    end
  end
`endif

  assign miso = miso_r;
  assign wel  = wel_r;
  assign busy = busy_s;

endmodule
